seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clock  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE or STOPPED.
REQ-005 abort  input  1  synchronous cancel of an operation in progress.
REQ-006 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 multiplicand  input  WIDTH  operand M; sampled with start.
REQ-008 multiplier  input  WIDTH  operand Q; sampled with start.
REQ-009 product  output  2*WIDTH  result register.
REQ-010 busy  output  1  high in ADDING, SHIFTING and FIXUP.
REQ-011 ready  output  1  high in STOPPED; product is valid.
REQ-012 done  output  1  one-cycle pulse on the first cycle of STOPPED.

Function
REQ-013 The block SHALL implement states IDLE, ADDING, SHIFTING, FIXUP and STOPPED.
REQ-014 IDLE/STOPPED with start=1: the block SHALL go to ADDING, latch |M| and |Q|, clear the accumulator and carry, set count=WIDTH, and latch neg = signed_mode & (M[msb] ^ Q[msb]).
REQ-015 Absolute value: signed_mode=0 uses the operands unchanged; signed_mode=1 negates an operand whose msb is 1. The value -2^(WIDTH-1) SHALL map to 2^(WIDTH-1) as unsigned WIDTH bits.
REQ-016 ADDING: when Q-register bit 0 = 1, the block SHALL set {C,A} <= A + Mreg (WIDTH+1 bits); it SHALL decrement count by 1 and go to SHIFTING.
REQ-017 SHIFTING: the block SHALL logically shift {C,A,Q} right by 1 with C <= 0; count>0 SHALL go to ADDING, and count=0 SHALL go to FIXUP.
REQ-018 FIXUP: product SHALL become {A,Q}, two's-complement negated if neg=1; the block SHALL then go to STOPPED.
REQ-019 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+2*WIDTH+1; total 2*WIDTH+1 busy cycles.
REQ-020 product SHALL hold its value throughout STOPPED until the next accepted start; it SHALL be exact for all operand pairs in both modes (no overflow in 2*WIDTH bits).
REQ-021 start while busy=1 SHALL be ignored, and operand or mode changes while busy SHALL have no effect.
REQ-022 abort=1 while busy SHALL return the block to IDLE on the next edge, with product cleared and no done pulse; abort in IDLE or STOPPED SHALL have no effect.
REQ-023 abort and start both high in STOPPED: start SHALL win.
REQ-024 STOPPED with start=0 SHALL remain in STOPPED; IDLE with start=0 SHALL remain in IDLE.
REQ-025 The outputs busy, ready and done SHALL be mutually consistent: never busy & ready, and done SHALL imply ready.

Reset
REQ-026 n_rst=0 SHALL immediately force IDLE, product=0, busy=0, ready=0, done=0, count=0 and neg=0, including mid-operation.
REQ-027 After n_rst is released, the first accepted start SHALL behave identically to REQ-014.

Verification
REQ-028 WIDTH=8, unsigned, 255*255, start at edge 0 -> done high in the cycle after edge 17, product=16'hFE01, and ready held until the next start.
REQ-029 WIDTH=8, signed: -3*5 -> 16'hFFF1; -128*-128 -> 16'h4000; -128*127 -> 16'hC080; 0*-1 -> 16'h0000.
REQ-030 WIDTH=8, start pulsed at cycle 5 of an operation with different operands -> that start is ignored and the original product is delivered on time.
REQ-031 abort at cycle 6 of 200*3 -> IDLE next edge, product=0, no done pulse; a following start on 7*9 -> 16'h003F.
REQ-032 n_rst asserted asynchronously mid-SHIFTING -> all outputs 0 without waiting for a clock edge; the next run of 12*12 -> 16'h0090.
REQ-033 WIDTH=4 and WIDTH=16 builds -> an exhaustive run (WIDTH=4) or 10k random runs (WIDTH=16) in both modes match a reference model, with done latency 2*WIDTH+1.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-and-add multiplier, unsigned or two's-complement, 2*WIDTH+1 busy cycles
// Ports: clock/n_rst (async active-low reset); start, abort, signed_mode, multiplicand, multiplier in;
// product (2*WIDTH result, held while ready), busy, ready, done (one-cycle pulse entering STOPPED) out.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               n_rst,
  input  logic               start,
  input  logic               abort,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               ready,
  output logic               done
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, ADDING, SHIFTING, FIXUP, STOPPED} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, q_q, q_d, m_q, m_d, abs_m, abs_q;
  logic c_q, c_d, neg_q, neg_d, done_q, done_d;
  logic [CW-1:0] count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  // Negating the most negative value wraps to 2^(WIDTH-1), which is exactly the unsigned magnitude.
  assign abs_m = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  assign abs_q = (signed_mode && multiplier[WIDTH-1]) ? -multiplier : multiplier;
  assign busy = (state_q == ADDING) || (state_q == SHIFTING) || (state_q == FIXUP);
  assign ready = state_q == STOPPED;
  assign done = done_q;
  assign product = product_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    c_d = c_q;
    q_d = q_q;
    m_d = m_q;
    count_d = count_q;
    neg_d = neg_q;
    product_d = product_q;
    done_d = 1'b0;
    case (state_q)
      IDLE, STOPPED: if (start) begin
        state_d = ADDING;
        m_d = abs_m;
        q_d = abs_q;
        a_d = '0;
        c_d = 1'b0;
        count_d = CW'(WIDTH);
        neg_d = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      end
      ADDING: begin
        if (q_q[0]) {c_d, a_d} = {1'b0, a_q} + {1'b0, m_q};
        count_d = count_q - CW'(1);
        state_d = SHIFTING;
      end
      SHIFTING: begin
        {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[WIDTH-1:1]};
        state_d = (count_q == '0) ? FIXUP : ADDING;
      end
      FIXUP: begin
        product_d = neg_q ? -{a_q, q_q} : {a_q, q_q};
        done_d = 1'b1;
        state_d = STOPPED;
      end
      default: state_d = IDLE;
    endcase
    if (busy && abort) begin
      state_d = IDLE;
      product_d = '0;
      done_d = 1'b0;
    end
  end
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      a_q <= '0;
      c_q <= 1'b0;
      q_q <= '0;
      m_q <= '0;
      count_q <= '0;
      neg_q <= 1'b0;
      product_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      c_q <= c_d;
      q_q <= q_d;
      m_q <= m_d;
      count_q <= count_d;
      neg_q <= neg_d;
      product_q <= product_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: table-driven and scoreboarded checks of seq_multiplier at WIDTH=8
module tb_seq_multiplier;
  localparam int W = 8;
  localparam int LAT = 2*W + 1;
  typedef struct {
    logic s;
    logic [W-1:0] m;
    logic [W-1:0] q;
    logic [2*W-1:0] exp;
  } vec_t;
  logic clock = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic signed_mode = 1'b0;
  logic [W-1:0] multiplicand = '0;
  logic [W-1:0] multiplier = '0;
  logic [2*W-1:0] product;
  logic busy, ready, done;
  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] sb[$];
  vec_t vecs[10];
  seq_multiplier #(.WIDTH(W)) dut (
    .clock(clock), .n_rst(n_rst), .start(start), .abort(abort), .signed_mode(signed_mode),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .product(product), .busy(busy), .ready(ready), .done(done)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
    chk("consistency", {30'd0, busy & ready, done & ~ready}, 32'd0);
  endtask
  function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] m, input logic [W-1:0] q);
    logic [2*W-1:0] em, eq;
    em = s ? {{W{m[W-1]}}, m} : {{W{1'b0}}, m};
    eq = s ? {{W{q[W-1]}}, q} : {{W{1'b0}}, q};
    return em * eq;
  endfunction
  task automatic start_op(input logic s, input logic [W-1:0] m, input logic [W-1:0] q);
    signed_mode = s;
    multiplicand = m;
    multiplier = q;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy after start", busy, 1);
  endtask
  task automatic finish_op(input string name, input int glitch_at);
    int cyc = 0;
    logic [2*W-1:0] e;
    do begin
      if (cyc + 1 == glitch_at) begin
        start = 1'b1;
        signed_mode = ~signed_mode;
        multiplicand = W'($urandom);
        multiplier = W'($urandom);
      end
      tick();
      cyc++;
      start = 1'b0;
    end while (!done && cyc < 4*LAT);
    chk({name, " latency"}, cyc, LAT);
    e = (sb.size() > 0) ? sb.pop_front() : 'x;
    chk({name, " product"}, product, e);
    chk({name, " ready"}, ready, 1);
  endtask
  task automatic run_vec(input int i, input int glitch_at);
    sb.push_back(vecs[i].exp);
    start_op(vecs[i].s, vecs[i].m, vecs[i].q);
    finish_op($sformatf("vec%0d", i), glitch_at);
  endtask
  initial begin
    logic seen;
    logic s;
    logic [W-1:0] m, q;
    vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
    vecs[2] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[3] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[4] = '{1'b1, 8'h00, 8'hFF, 16'h0000};
    vecs[5] = '{1'b0, 8'd12, 8'd12, 16'h0090};
    vecs[6] = '{1'b0, 8'd7, 8'd9, 16'h003F};
    vecs[7] = '{1'b0, 8'h80, 8'hFF, 16'h7F80};
    vecs[8] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vecs[9] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    #3;
    chk("reset product", product, 0);
    chk("reset busy", busy, 0);
    chk("reset ready", ready, 0);
    chk("reset done", done, 0);
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    chk("idle hold ready", ready, 0);
    run_vec(0, 0);
    tick();
    chk("stopped done pulse", done, 0);
    chk("stopped ready", ready, 1);
    chk("stopped product", product, 16'hFE01);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort stopped ready", ready, 1);
    chk("abort stopped product", product, 16'hFE01);
    abort = 1'b1;
    sb.push_back(vecs[1].exp);
    start_op(vecs[1].s, vecs[1].m, vecs[1].q);
    abort = 1'b0;
    finish_op("start beats abort", 0);
    for (int i = 2; i < 10; i++) run_vec(i, 0);
    run_vec(1, 5);
    start_op(1'b0, 8'd200, 8'd3);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort ready", ready, 0);
    chk("abort product", product, 0);
    seen = 1'b0;
    repeat (LAT + 2) begin
      tick();
      seen = seen | done | ready;
    end
    chk("abort no done", seen, 0);
    run_vec(6, 0);
    start_op(1'b0, 8'd100, 8'd50);
    tick();
    #2 n_rst = 1'b0;
    #1;
    chk("async rst product", product, 0);
    chk("async rst busy", busy, 0);
    chk("async rst ready", ready, 0);
    chk("async rst done", done, 0);
    #3 n_rst = 1'b1;
    tick();
    run_vec(5, 0);
    for (int i = 0; i < 150; i++) begin
      s = 1'($urandom_range(0, 1));
      m = W'($urandom);
      q = W'($urandom);
      sb.push_back(ref_mul(s, m, q));
      start_op(s, m, q);
      finish_op($sformatf("rand%0d", i), (i % 3 == 0) ? int'($urandom_range(1, LAT)) : 0);
    end
    chk("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
